scroll_display_ctrl: RTL and testbench

Sequencer and write arbiter for the scrolling character buffer that drives the 8-digit hex display. It shares the buffer's single write port between the CPU and the CAN RX path, and periodically fetches a display frame of DIGITS characters by pulsing next_char. It latches each frame into stable digit registers and advances the scroll window by one character every SCROLL_DIV frames.

---
 rtl/scroll_ctrl_pkg.sv | 26 ++
 rtl/scroll_wr_arbiter.sv | 55 +++++
 rtl/scroll_display_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_scroll_display_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scroll_ctrl_pkg.sv
// rtl/scroll_ctrl_pkg.sv - shared types and constants for the scrolling display controller
//
// Contents: character width, blank glyph code, controller state encoding,
// and a counter-width helper that never returns zero.

package scroll_ctrl_pkg;

  localparam int CHAR_W = 5;
  localparam logic [CHAR_W-1:0] BLANK_CHAR = 5'b10000;

  typedef logic [CHAR_W-1:0] char_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DRAIN  = 3'd2,
    COMMIT = 3'd3,
    SKIP   = 3'd4
  } state_t;

  // Width of a counter covering 0..div-1; a divider of 1 still needs one bit.
  function automatic int cnt_w(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/scroll_wr_arbiter.sv
// rtl/scroll_wr_arbiter.sv - 2-way round-robin write arbiter for the character buffer
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   en                  grants may only be issued while 1
//   cpu_req, cpu_data   CPU requester
//   rx_req, rx_data     CAN RX requester
//   cpu_gnt, rx_gnt     1-cycle grants (combinational, same cycle as wr)
//   wr, data            buffer write strobe and selected character (0 when idle)

module scroll_wr_arbiter
  import scroll_ctrl_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  en,
  input  logic  cpu_req,
  input  char_t cpu_data,
  input  logic  rx_req,
  input  char_t rx_data,
  output logic  cpu_gnt,
  output logic  rx_gnt,
  output logic  wr,
  output char_t data
);

  // 0: CPU wins a tie, 1: RX wins a tie.
  logic rr_rx;

  always_comb begin
    cpu_gnt = 1'b0;
    rx_gnt  = 1'b0;
    if (en) begin
      if (cpu_req && (!rx_req || !rr_rx)) begin
        cpu_gnt = 1'b1;
      end else if (rx_req) begin
        rx_gnt = 1'b1;
      end
    end
    wr   = cpu_gnt | rx_gnt;
    data = rx_gnt ? rx_data : (cpu_gnt ? cpu_data : '0);
  end

  // The pointer hands priority to the other side after every grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_rx <= 1'b0;
    end else if (cpu_gnt) begin
      rr_rx <= 1'b1;
    end else if (rx_gnt) begin
      rr_rx <= 1'b0;
    end
  end

endmodule

// File: rtl/scroll_display_ctrl.sv
// rtl/scroll_display_ctrl.sv - frame fetch sequencer and write arbiter for the scrolling hex display
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   enable                         gates the refresh counter (arbitration always runs)
//   cpu_wr_req/data, cpu_wr_gnt    CPU character writes
//   rx_wr_req/data, rx_wr_gnt      CAN RX character writes
//   clr_req, clr_ack               buffer clear handshake
//   buffer_clear/write/data        buffer write port
//   next_char, hex_char            buffer read port (hex_char valid cycle after next_char)
//   digits                         committed frame, digit 0 in bits [4:0]
//   frame_done                     high in the cycle the digits register is loaded
//   busy                           high whenever not IDLE
//   scroll_pause                   only with SCROLL_PAUSE_EN: freezes the scroll step

module scroll_display_ctrl
  import scroll_ctrl_pkg::*;
#(
  parameter int DIGITS      = 8,
  parameter int REFRESH_DIV = 50000,
  parameter int SCROLL_DIV  = 25
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic                     cpu_wr_req,
  input  logic [CHAR_W-1:0]        cpu_wr_data,
  output logic                     cpu_wr_gnt,
  input  logic                     rx_wr_req,
  input  logic [CHAR_W-1:0]        rx_wr_data,
  output logic                     rx_wr_gnt,
  input  logic                     clr_req,
  output logic                     clr_ack,
  output logic                     buffer_clear,
  output logic                     buffer_write,
  output logic [CHAR_W-1:0]        buffer_data,
  output logic                     next_char,
  input  logic [CHAR_W-1:0]        hex_char,
`ifdef SCROLL_PAUSE_EN
  input  logic                     scroll_pause,
`endif
  output logic [DIGITS*CHAR_W-1:0] digits,
  output logic                     frame_done,
  output logic                     busy
);

  localparam int RW = cnt_w(REFRESH_DIV);
  localparam int FW = cnt_w(SCROLL_DIV);
  localparam int IW = cnt_w(DIGITS);

  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [FW-1:0] SCROLL_LAST  = FW'(SCROLL_DIV - 1);
  localparam logic [IW-1:0] DIGIT_LAST   = IW'(DIGITS - 1);

  state_t        state, next_state;
  logic [RW-1:0] refresh_cnt;
  logic          frame_due;
  logic [FW-1:0] frame_cnt;
  logic [IW-1:0] fetch_cnt;
  logic          cap_en;
  logic [IW-1:0] cap_idx;
  char_t         cap [DIGITS];

  logic          pause;
  logic          refresh_wrap;
  logic          start_frame;
  logic          clr_take;
  logic          wr_en;

`ifdef SCROLL_PAUSE_EN
  assign pause = scroll_pause;
`else
  assign pause = 1'b0;
`endif

  assign refresh_wrap = enable && (refresh_cnt == REFRESH_LAST);
  assign busy         = (state != IDLE);

  always_comb begin
    next_state   = state;
    next_char    = 1'b0;
    buffer_clear = 1'b0;
    clr_ack      = 1'b0;
    frame_done   = 1'b0;
    start_frame  = 1'b0;
    clr_take     = 1'b0;
    wr_en        = 1'b0;
    case (state)
      IDLE: begin
        if (clr_req) begin
          clr_take     = 1'b1;
          buffer_clear = 1'b1;
          clr_ack      = 1'b1;
        end else if (frame_due) begin
          start_frame = 1'b1;
          next_state  = FETCH;
        end else begin
          wr_en = 1'b1;
        end
      end
      FETCH: begin
        next_char = 1'b1;
        if (fetch_cnt == DIGIT_LAST) begin
          next_state = DRAIN;
        end
      end
      DRAIN: begin
        next_state = COMMIT;
      end
      COMMIT: begin
        frame_done = 1'b1;
        next_state = (!pause && (frame_cnt == SCROLL_LAST)) ? SKIP : IDLE;
      end
      SKIP: begin
        // Extra read with the result dropped: shifts the window one character.
        next_char  = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      refresh_cnt <= '0;
      frame_due   <= 1'b0;
      frame_cnt   <= '0;
      fetch_cnt   <= '0;
      cap_en      <= 1'b0;
      cap_idx     <= '0;
    end else begin
      state <= next_state;

      if (enable) begin
        refresh_cnt <= refresh_wrap ? '0 : refresh_cnt + RW'(1);
      end

      // A wrap wins over the clear so a due frame is never lost.
      if (refresh_wrap) begin
        frame_due <= 1'b1;
      end else if (start_frame) begin
        frame_due <= 1'b0;
      end

      if (clr_take) begin
        frame_cnt <= '0;
      end else if ((state == COMMIT) && !pause) begin
        frame_cnt <= (frame_cnt == SCROLL_LAST) ? '0 : frame_cnt + FW'(1);
      end

      fetch_cnt <= (state == FETCH && fetch_cnt != DIGIT_LAST) ? fetch_cnt + IW'(1) : '0;

      // Read data lags the pulse by one cycle, so remember which slot it belongs to.
      cap_en  <= (state == FETCH);
      cap_idx <= fetch_cnt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DIGITS; i++) begin
        cap[i] <= BLANK_CHAR;
      end
    end else if (cap_en) begin
      cap[cap_idx] <= hex_char;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits <= {DIGITS{BLANK_CHAR}};
    end else if (clr_take) begin
      digits <= {DIGITS{BLANK_CHAR}};
    end else if (state == COMMIT) begin
      for (int i = 0; i < DIGITS; i++) begin
        digits[i*CHAR_W +: CHAR_W] <= cap[i];
      end
    end
  end

  scroll_wr_arbiter u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (wr_en),
    .cpu_req  (cpu_wr_req),
    .cpu_data (cpu_wr_data),
    .rx_req   (rx_wr_req),
    .rx_data  (rx_wr_data),
    .cpu_gnt  (cpu_wr_gnt),
    .rx_gnt   (rx_wr_gnt),
    .wr       (buffer_write),
    .data     (buffer_data)
  );

endmodule

// File: tb/tb_scroll_display_ctrl.sv
// tb/tb_scroll_display_ctrl.sv - directed self-checking bench for scroll_display_ctrl

module tb_scroll_display_ctrl;
  import scroll_ctrl_pkg::*;

  localparam int DIGITS = 8;
  localparam int RD     = 40;
  localparam int SD     = 2;
  localparam int DW     = DIGITS * CHAR_W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b1;
  logic          cpu_wr_req = 1'b0;
  logic [4:0]    cpu_wr_data = '0;
  logic          cpu_wr_gnt;
  logic          rx_wr_req = 1'b0;
  logic [4:0]    rx_wr_data = '0;
  logic          rx_wr_gnt;
  logic          clr_req = 1'b0;
  logic          clr_ack;
  logic          buffer_clear;
  logic          buffer_write;
  logic [4:0]    buffer_data;
  logic          next_char;
  logic [4:0]    hex_char = '0;
  logic [DW-1:0] digits;
  logic          frame_done;
  logic          busy;

  int checks = 0;
  int errors = 0;

  // Buffer model: 8 characters 1..8 read sequentially, wrapping.
  char_t mem [8];
  int    ptr = 0;

  logic [DW-1:0] blank_frame;
  assign blank_frame = {DIGITS{BLANK_CHAR}};

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (next_char) begin
      hex_char <= mem[ptr];
      ptr      <= (ptr + 1) % 8;
    end
  end

  scroll_display_ctrl #(
    .DIGITS      (DIGITS),
    .REFRESH_DIV (RD),
    .SCROLL_DIV  (SD)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .cpu_wr_req   (cpu_wr_req),
    .cpu_wr_data  (cpu_wr_data),
    .cpu_wr_gnt   (cpu_wr_gnt),
    .rx_wr_req    (rx_wr_req),
    .rx_wr_data   (rx_wr_data),
    .rx_wr_gnt    (rx_wr_gnt),
    .clr_req      (clr_req),
    .clr_ack      (clr_ack),
    .buffer_clear (buffer_clear),
    .buffer_write (buffer_write),
    .buffer_data  (buffer_data),
    .next_char    (next_char),
    .hex_char     (hex_char),
`ifdef SCROLL_PAUSE_EN
    .scroll_pause (1'b0),
`endif
    .digits       (digits),
    .frame_done   (frame_done),
    .busy         (busy)
  );

  // Expected frame when the window starts at model position start.
  function automatic logic [DW-1:0] pack(input int start);
    logic [DW-1:0] r;
    for (int i = 0; i < DIGITS; i++) begin
      r[i*CHAR_W +: CHAR_W] = char_t'(((start + i) % 8) + 1);
    end
    return r;
  endfunction

  // Returns at the negedge of the first FETCH cycle; n = posedges waited.
  task automatic wait_fetch(output int n, output int start);
    n = 0;
    while (n < 400) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (next_char) break;
    end
    checks++;
    if (next_char !== 1'b1) begin
      errors++;
      $display("FAIL wait_fetch: next_char=%b after %0d cycles, required 1", next_char, n);
    end
    start = ptr;
  endtask

  task automatic finish_frame(input logic [DW-1:0] exp, input bit exp_skip, input string tag);
    int p;
    p = 1;
    while (next_char && p < 50) begin
      @(negedge clk);
      if (next_char) p++;
    end
    checks++;
    if (p !== DIGITS) begin
      errors++;
      $display("FAIL %s pulses: got %0d, required %0d", tag, p, DIGITS);
    end
    @(negedge clk);
    checks++;
    if (frame_done !== 1'b1) begin
      errors++;
      $display("FAIL %s frame_done: got %b, required 1", tag, frame_done);
    end
    @(negedge clk);
    checks++;
    if (digits !== exp) begin
      errors++;
      $display("FAIL %s digits: got %h, required %h", tag, digits, exp);
    end
    checks++;
    if (next_char !== exp_skip) begin
      errors++;
      $display("FAIL %s skip pulse: got %b, required %b", tag, next_char, exp_skip);
    end
    if (exp_skip) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s back to idle: busy=%b, required 0", tag, busy);
    end
  endtask

  task automatic test_reset;
    logic [12:0] outs;
    int n, s;
    @(posedge clk);
    @(negedge clk);
    outs = {cpu_wr_gnt, rx_wr_gnt, clr_ack, buffer_clear, buffer_write,
            buffer_data, next_char, frame_done, busy};
    checks++;
    if (outs !== 13'd0) begin
      errors++;
      $display("FAIL reset outputs: got %h, required 0", outs);
    end
    checks++;
    if (digits !== {5'h10, 5'h10, 5'h10, 5'h10, 5'h10, 5'h10, 5'h10, 5'h10}) begin
      errors++;
      $display("FAIL reset digits: got %h, required all blank", digits);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    wait_fetch(n, s);
    checks++;
    if (n !== RD + 1) begin
      errors++;
      $display("FAIL first fetch latency: got %0d, required %0d", n, RD + 1);
    end
    finish_frame({5'd8, 5'd7, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1}, 1'b0, "frame1");
  endtask

  task automatic test_scroll;
    int n, s;
    wait_fetch(n, s);
    finish_frame({5'd8, 5'd7, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1}, 1'b1, "frame2");
    wait_fetch(n, s);
    finish_frame({5'd1, 5'd8, 5'd7, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2}, 1'b0, "frame3");
  endtask

  task automatic test_round_robin;
    logic [2:0] exp_g;
    logic [4:0] exp_d;
    cpu_wr_data = 5'h3;
    rx_wr_data  = 5'h7;
    cpu_wr_req  = 1'b1;
    rx_wr_req   = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      exp_g = (k == 1) ? 3'b011 : 3'b101;
      exp_d = (k == 1) ? 5'h7 : 5'h3;
      checks++;
      if ({cpu_wr_gnt, rx_wr_gnt, buffer_write} !== exp_g) begin
        errors++;
        $display("FAIL rr grant %0d: got %b, required %b", k,
                 {cpu_wr_gnt, rx_wr_gnt, buffer_write}, exp_g);
      end
      checks++;
      if (buffer_data !== exp_d) begin
        errors++;
        $display("FAIL rr data %0d: got %h, required %h", k, buffer_data, exp_d);
      end
      @(negedge clk);
    end
    cpu_wr_req = 1'b0;
    rx_wr_req  = 1'b0;
  endtask

  task automatic test_back_to_back_stall;
    int n, s, viol, cyc;
    wait_fetch(n, s);
    rx_wr_data = 5'h0a;
    rx_wr_req  = 1'b1;
    viol = 0;
    cyc  = 0;
    #1;
    while (busy && cyc < 40) begin
      if (rx_wr_gnt || cpu_wr_gnt || buffer_write) viol++;
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (viol !== 0) begin
      errors++;
      $display("FAIL stall writes while busy: got %0d, required 0", viol);
    end
    checks++;
    if ({busy, rx_wr_gnt, buffer_write} !== 3'b011) begin
      errors++;
      $display("FAIL stall grant at idle: busy/gnt/wr=%b, required 011",
               {busy, rx_wr_gnt, buffer_write});
    end
    checks++;
    if (buffer_data !== 5'h0a) begin
      errors++;
      $display("FAIL stall data: got %h, required 0a", buffer_data);
    end
    rx_wr_req = 1'b0;
  endtask

  task automatic test_reset_mid_fetch;
    int n, s;
    wait_fetch(n, s);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({next_char, busy} !== 2'b00) begin
      errors++;
      $display("FAIL async reset next_char/busy: got %b, required 00", {next_char, busy});
    end
    checks++;
    if (digits !== blank_frame) begin
      errors++;
      $display("FAIL async reset digits: got %h, required %h", digits, blank_frame);
    end
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    wait_fetch(n, s);
    checks++;
    if (n !== RD + 1) begin
      errors++;
      $display("FAIL fetch latency after reset: got %0d, required %0d", n, RD + 1);
    end
    finish_frame(pack(s), 1'b0, "after_reset");
  endtask

  task automatic test_clear;
    int n, s, early, cyc;
    wait_fetch(n, s);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    clr_req = 1'b1;
    early = 0;
    cyc   = 0;
    #1;
    while (busy && cyc < 40) begin
      if (clr_ack || buffer_clear) early++;
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (early !== 0) begin
      errors++;
      $display("FAIL clear served while busy: got %0d, required 0", early);
    end
    checks++;
    if (digits !== pack(s)) begin
      errors++;
      $display("FAIL frame before clear: got %h, required %h", digits, pack(s));
    end
    checks++;
    if ({clr_ack, buffer_clear, buffer_write} !== 3'b110) begin
      errors++;
      $display("FAIL clear ack: ack/clear/write=%b, required 110",
               {clr_ack, buffer_clear, buffer_write});
    end
    @(posedge clk);
    #1 clr_req = 1'b0;
    @(negedge clk);
    checks++;
    if (digits !== blank_frame) begin
      errors++;
      $display("FAIL digits after clear: got %h, required %h", digits, blank_frame);
    end
    checks++;
    if (clr_ack !== 1'b0) begin
      errors++;
      $display("FAIL clr_ack after release: got %b, required 0", clr_ack);
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = char_t'(i + 1);
    test_reset();
    test_scroll();
    test_round_robin();
    test_back_to_back_stall();
    test_reset_mid_fetch();
    test_clear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
